processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter RESET_PC, default 3'd0; the PC value loaded while reset is active.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port instruction, input, 16 bits; the word fetched from address; driven combinationally by an external 8x16 program ROM with zero latency.
REQ-005 SHALL have port address, output, 3 bits; the current PC, driven directly from the PC register.
REQ-006 SHALL have port result, output, 16 bits; the registered output value.

Function
REQ-007 SHALL execute one instruction per clk rising edge; single-cycle, no pipeline, no stalls.
REQ-008 SHALL decode the instruction fields as: op=[15:12], rd=[11:10], rs=[9:8], imm=[7:0].
REQ-009 SHALL hold four 16-bit registers R0-R3; all arithmetic is modulo 2^16; there is no carry or flag state.
REQ-010 SHALL implement op 0x0 NOP: no state change other than the PC.
REQ-011 SHALL implement op 0x1 LDI: rd <= zero-extended imm.
REQ-012 SHALL implement op 0x2 ADD: rd <= rd+rs.
REQ-013 SHALL implement op 0x3 SUB: rd <= rd-rs, with two's-complement wrap.
REQ-014 SHALL implement op 0x4 AND, 0x5 OR and 0x6 XOR: rd <= rd op rs.
REQ-015 SHALL implement op 0x7 SHL: rd <= rd << imm[3:0]; op 0x8 SHR: rd <= rd >> imm[3:0], logical, zero fill.
REQ-016 SHALL implement op 0x9 ADDI: rd <= rd + sign-extended imm.
REQ-017 SHALL implement op 0xA JMP: pc <= imm[2:0].
REQ-018 SHALL implement op 0xB BEQZ: pc <= imm[2:0] if rd==0, else pc+1.
REQ-019 SHALL implement op 0xC OUT: result <= rd, visible one cycle after the edge on which OUT executes.
REQ-020 SHALL treat op 0xD, 0xE, and 0xF (when the halt feature is excluded) as NOP.
REQ-021 SHALL advance pc <= pc+1 for every non-branch instruction, wrapping from 7 to 0.
REQ-022 SHALL use the old register value for a source that is also the destination (e.g. ADD R1,R1 doubles R1).
REQ-023 SHALL change result only on OUT; result holds its value otherwise.

Reset
REQ-024 SHALL, while rst_n=0 and regardless of clk, force pc=RESET_PC, R0-R3=0, result=0 and halted=0.
REQ-025 SHALL execute the first instruction on the first clk rising edge after rst_n rises.
REQ-026 SHALL, when rst_n is asserted mid-program, abandon any in-flight register write; no partial update is permitted.

Configuration
REQ-027 SHALL, with macro PROCESSOR_HALT_EN defined, decode op 0xF as HALT: it sets halted; while halted, pc, registers and result freeze until reset.
REQ-028 SHALL, without PROCESSOR_HALT_EN, decode op 0xF as NOP with no halted state.

Verification
REQ-029 SHALL cover: ROM = LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0 -> result=0x0008 after 4th edge, address sequence 0,1,2,3,4.
REQ-030 SHALL cover: LDI R0,0; ADDI R0,-1; OUT R0 -> result=0xFFFF (wrap); SHR R0,12; OUT R0 -> result=0x000F.
REQ-031 SHALL cover: ROM of all NOPs -> address counts 0..7 then 0 (wrap).
REQ-032 SHALL cover: LDI R2,0; BEQZ R2,6 -> next address 6; LDI R2,1; BEQZ R2,6 -> next address = pc+1.
REQ-033 SHALL cover: rst_n pulsed low between edges mid-program -> address=0 and result=0 immediately, without waiting for clk.
REQ-034 SHALL cover: with PROCESSOR_HALT_EN, OUT R0 (=7) then HALT -> address and result=7 constant for 10 cycles; without the macro, address continues incrementing.

Source files
------------

// File: rtl/processor.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// processor
//
// Single-cycle 16-bit accumulator-style processor with a 3-bit PC. The
// instruction is fetched combinationally from an external 8x16 ROM at
// 'address'. Each rising edge of clk executes that word completely: it
// updates at most one of the four registers, the PC, and 'result'.
//
// Instruction word: op=[15:12], rd=[11:10], rs=[9:8], imm=[7:0].
//
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   rst_n       - asynchronous active-low reset
//   instruction - ROM word at 'address' (zero-latency, combinational)
//   address     - current PC
//   result      - registered output, written only by OUT
//
// Optional feature: define PROCESSOR_HALT_EN to decode op 0xF as HALT,
// which freezes pc, registers and result until reset. Without it, 0xF
// is a NOP.
// ----------------------------------------------------------------------------
module processor #(
    parameter logic [2:0] RESET_PC = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    output logic [2:0]  address,
    output logic [15:0] result
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ADDI = 4'h9,
        OP_JMP  = 4'hA,
        OP_BEQZ = 4'hB,
        OP_OUT  = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    // Decoded fields
    opcode_t     op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;

    assign op  = opcode_t'(instruction[15:12]);
    assign rd  = instruction[11:10];
    assign rs  = instruction[9:8];
    assign imm = instruction[7:0];

    // Architectural state
    logic [15:0] regs [4];
    logic [2:0]  pc;

    // Next-state signals
    logic [15:0] rd_val;
    logic [15:0] rs_val;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        out_en;
    logic [2:0]  pc_next;
    logic        run;

    // Operands are read from the current register values, so an instruction
    // whose source is also its destination sees the old value.
    assign rd_val  = regs[rd];
    assign rs_val  = regs[rs];
    assign address = pc;

`ifdef PROCESSOR_HALT_EN
    logic halted;
    logic halt_now;

    assign run = ~halted;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        wr_en   = 1'b0;
        wr_data = rd_val;
        out_en  = 1'b0;
        pc_next = pc + 3'd1;
`ifdef PROCESSOR_HALT_EN
        halt_now = 1'b0;
`endif
        case (op)
            OP_LDI:  begin wr_en = 1'b1; wr_data = {8'd0, imm};            end
            OP_ADD:  begin wr_en = 1'b1; wr_data = rd_val + rs_val;        end
            OP_SUB:  begin wr_en = 1'b1; wr_data = rd_val - rs_val;        end
            OP_AND:  begin wr_en = 1'b1; wr_data = rd_val & rs_val;        end
            OP_OR:   begin wr_en = 1'b1; wr_data = rd_val | rs_val;        end
            OP_XOR:  begin wr_en = 1'b1; wr_data = rd_val ^ rs_val;        end
            OP_SHL:  begin wr_en = 1'b1; wr_data = rd_val << imm[3:0];     end
            OP_SHR:  begin wr_en = 1'b1; wr_data = rd_val >> imm[3:0];     end
            OP_ADDI: begin wr_en = 1'b1; wr_data = rd_val + {{8{imm[7]}}, imm}; end
            OP_JMP:  pc_next = imm[2:0];
            OP_BEQZ: if (rd_val == 16'd0) pc_next = imm[2:0];
            OP_OUT:  out_en = 1'b1;
`ifdef PROCESSOR_HALT_EN
            // The PC stays on the HALT word so 'address' points at it.
            OP_HALT: begin halt_now = 1'b1; pc_next = pc; end
`endif
            default: ;  // NOP and reserved opcodes only advance the PC
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is only four words of flops, and it must
            // read as zero after reset, so it is cleared here like any other
            // register rather than treated as an unreset RAM.
            pc     <= RESET_PC;
            result <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef PROCESSOR_HALT_EN
            halted <= 1'b0;
`endif
        end else if (run) begin
            // NOTE: non-blocking assignments so all state updates of one
            // instruction take effect together at the edge.
            pc <= pc_next;
            if (wr_en)  regs[rd] <= wr_data;
            if (out_en) result   <= rd_val;
`ifdef PROCESSOR_HALT_EN
            if (halt_now) halted <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_processor.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_processor
//
// Directed bench for processor. Each program is loaded into a bench-side ROM
// while reset is held; the expected address/result after every following
// clock edge is pushed to a scoreboard queue and popped when that edge has
// executed. Define PROCESSOR_HALT_EN for both RTL and bench to exercise HALT.
// ----------------------------------------------------------------------------
module tb_processor;

    localparam logic [3:0] I_NOP  = 4'h0;
    localparam logic [3:0] I_LDI  = 4'h1;
    localparam logic [3:0] I_ADD  = 4'h2;
    localparam logic [3:0] I_SUB  = 4'h3;
    localparam logic [3:0] I_AND  = 4'h4;
    localparam logic [3:0] I_OR   = 4'h5;
    localparam logic [3:0] I_XOR  = 4'h6;
    localparam logic [3:0] I_SHL  = 4'h7;
    localparam logic [3:0] I_SHR  = 4'h8;
    localparam logic [3:0] I_ADDI = 4'h9;
    localparam logic [3:0] I_JMP  = 4'hA;
    localparam logic [3:0] I_BEQZ = 4'hB;
    localparam logic [3:0] I_OUT  = 4'hC;
    localparam logic [3:0] I_HALT = 4'hF;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic [2:0]  address;
    logic [15:0] result;

    logic [15:0] rom [8];

    int n_checks;
    int n_fail;

    typedef struct {
        string       tag;
        logic [2:0]  addr;
        logic [15:0] res;
    } exp_t;

    exp_t sb[$];

    processor #(.RESET_PC(3'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .address     (address),
        .result      (result)
    );

    assign instruction = rom[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] a, input logic [15:0] r);
        exp_t e;
        e.tag  = tag;
        e.addr = a;
        e.res  = r;
        sb.push_back(e);
    endtask

    // One clock edge per queued entry, compared 1 ns after the edge.
    task automatic run_expected();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.tag, " addr"},   {13'd0, address}, {13'd0, e.addr});
            check({e.tag, " result"}, result, e.res);
        end
    endtask

    // Reset between edges, check reset state without a clock, load program
    // (caller fills rom first), release reset away from the rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({tag, " reset addr"},   {13'd0, address}, 16'd0);
        check({tag, " reset result"}, result, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = enc(I_NOP, 2'd0, 2'd0, 8'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        clear_rom();

        // ---- Program 1: LDI/LDI/ADD/OUT, address 0..4 ----
        clear_rom();
        rom[0] = enc(I_LDI, 2'd0, 2'd0, 8'd5);
        rom[1] = enc(I_LDI, 2'd1, 2'd0, 8'd3);
        rom[2] = enc(I_ADD, 2'd0, 2'd1, 8'd0);
        rom[3] = enc(I_OUT, 2'd0, 2'd0, 8'd0);
        do_reset("p1");
        push_exp("p1 e1", 3'd1, 16'h0000);
        push_exp("p1 e2", 3'd2, 16'h0000);
        push_exp("p1 e3", 3'd3, 16'h0000);
        push_exp("p1 e4", 3'd4, 16'h0008);
        push_exp("p1 e5", 3'd5, 16'h0008);
        run_expected();

        // Asynchronous reset pulse between edges
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst addr",   {13'd0, address}, 16'd0);
        check("async rst result", result, 16'd0);
        #1;
        rst_n = 1'b1;
        push_exp("p1r e1", 3'd1, 16'h0000);
        push_exp("p1r e2", 3'd2, 16'h0000);
        push_exp("p1r e3", 3'd3, 16'h0000);
        push_exp("p1r e4", 3'd4, 16'h0008);
        run_expected();

        // ---- Program 2: ADDI wrap, SHR, SHL ----
        clear_rom();
        rom[0] = enc(I_LDI,  2'd0, 2'd0, 8'd0);
        rom[1] = enc(I_ADDI, 2'd0, 2'd0, 8'hFF);
        rom[2] = enc(I_OUT,  2'd0, 2'd0, 8'd0);
        rom[3] = enc(I_SHR,  2'd0, 2'd0, 8'd12);
        rom[4] = enc(I_OUT,  2'd0, 2'd0, 8'd0);
        rom[5] = enc(I_SHL,  2'd0, 2'd0, 8'd4);
        rom[6] = enc(I_OUT,  2'd0, 2'd0, 8'd0);
        do_reset("p2");
        push_exp("p2 e1", 3'd1, 16'h0000);
        push_exp("p2 e2", 3'd2, 16'h0000);
        push_exp("p2 e3", 3'd3, 16'hFFFF);
        push_exp("p2 e4", 3'd4, 16'hFFFF);
        push_exp("p2 e5", 3'd5, 16'h000F);
        push_exp("p2 e6", 3'd6, 16'h000F);
        push_exp("p2 e7", 3'd7, 16'h00F0);
        push_exp("p2 e8", 3'd0, 16'h00F0);
        run_expected();

        // ---- Program 3: NOPs and reserved ops, PC wraps 7 -> 0 ----
        clear_rom();
        rom[2] = enc(4'hD, 2'd1, 2'd1, 8'hFF);
        rom[5] = enc(4'hE, 2'd2, 2'd3, 8'h81);
        do_reset("p3");
        for (int i = 1; i <= 9; i++) push_exp("p3 nop", 3'(i), 16'h0000);
        run_expected();

        // ---- Program 4: BEQZ taken and not taken ----
        clear_rom();
        rom[0] = enc(I_LDI,  2'd2, 2'd0, 8'd0);
        rom[1] = enc(I_BEQZ, 2'd2, 2'd0, 8'd6);
        rom[6] = enc(I_LDI,  2'd2, 2'd0, 8'd1);
        rom[7] = enc(I_BEQZ, 2'd2, 2'd0, 8'd6);
        do_reset("p4");
        push_exp("p4 ldi0",  3'd1, 16'h0000);
        push_exp("p4 taken", 3'd6, 16'h0000);
        push_exp("p4 ldi1",  3'd7, 16'h0000);
        push_exp("p4 fall",  3'd0, 16'h0000);
        run_expected();

        // ---- Program 5: XOR, ADD self, SUB wrap, AND ----
        clear_rom();
        rom[0] = enc(I_LDI, 2'd1, 2'd0, 8'h0D);
        rom[1] = enc(I_LDI, 2'd3, 2'd0, 8'h0A);
        rom[2] = enc(I_XOR, 2'd1, 2'd3, 8'd0);  // R1 = 0x0007
        rom[3] = enc(I_ADD, 2'd1, 2'd1, 8'd0);  // R1 = 0x000E
        rom[4] = enc(I_SUB, 2'd3, 2'd1, 8'd0);  // R3 = 0xFFFC
        rom[5] = enc(I_OUT, 2'd3, 2'd0, 8'd0);
        rom[6] = enc(I_AND, 2'd3, 2'd1, 8'd0);  // R3 = 0x000C
        rom[7] = enc(I_OUT, 2'd3, 2'd0, 8'd0);
        do_reset("p5");
        push_exp("p5 e1", 3'd1, 16'h0000);
        push_exp("p5 e2", 3'd2, 16'h0000);
        push_exp("p5 e3", 3'd3, 16'h0000);
        push_exp("p5 e4", 3'd4, 16'h0000);
        push_exp("p5 e5", 3'd5, 16'h0000);
        push_exp("p5 sub", 3'd6, 16'hFFFC);
        push_exp("p5 e7", 3'd7, 16'hFFFC);
        push_exp("p5 and", 3'd0, 16'h000C);
        run_expected();

        // ---- Program 6: OR, JMP, OUT then HALT (or NOP) ----
        clear_rom();
        rom[0] = enc(I_LDI,  2'd0, 2'd0, 8'd5);
        rom[1] = enc(I_LDI,  2'd2, 2'd0, 8'd2);
        rom[2] = enc(I_OR,   2'd0, 2'd2, 8'd0);  // R0 = 7
        rom[3] = enc(I_JMP,  2'd0, 2'd0, 8'd6);
        rom[4] = enc(I_LDI,  2'd0, 2'd0, 8'hFF); // skipped
        rom[5] = enc(I_LDI,  2'd0, 2'd0, 8'hFF); // skipped
        rom[6] = enc(I_OUT,  2'd0, 2'd0, 8'd0);
        rom[7] = enc(I_HALT, 2'd0, 2'd0, 8'd0);
        do_reset("p6");
        push_exp("p6 e1",  3'd1, 16'h0000);
        push_exp("p6 e2",  3'd2, 16'h0000);
        push_exp("p6 e3",  3'd3, 16'h0000);
        push_exp("p6 jmp", 3'd6, 16'h0000);
        push_exp("p6 out", 3'd7, 16'h0007);
`ifdef PROCESSOR_HALT_EN
        for (int i = 0; i < 10; i++) push_exp("p6 halted", 3'd7, 16'h0007);
`else
        begin
            logic [2:0] seq [10];
            seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
            for (int i = 0; i < 10; i++) push_exp("p6 nohalt", seq[i], 16'h0007);
        end
`endif
        run_expected();

        // Reset must clear any halt and restart the program.
        do_reset("p6r");
        push_exp("p6r e1", 3'd1, 16'h0000);
        push_exp("p6r e2", 3'd2, 16'h0000);
        run_expected();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
